generation_ctrl: RTL and testbench
==================================

# generation_ctrl

Sequences one Game of Life generation over the double-buffered cell memory. Sweeps every word of the current (read) buffer through the logic port, hands each word to the update kernel, writes kernel results into the back buffer, then issues a single-cycle buffer swap aligned to a frame boundary so the renderer never displays a half-updated board. Sits between the double buffer's logic-side ports and the cell-update kernel.

## Interface
- `MAX_ADDR`, 4800: words per buffer; the sweep covers addresses 0..MAX_ADDR-1.
- `ADDR_W`, `LOG_MAX_ADDR`: address width; must satisfy 2^ADDR_W ≥ MAX_ADDR.
- `DATA_W`, `WORD_SIZE`: word width.
- `READ_LAT`, 2: cycles from `rd_addr_out` to valid `logic_data_r_in`; 1..4.

Ports:
- `clk_in` in 1: single clock.
- `rst_in` in 1: asynchronous, active-high reset.
- `run_in` in 1: level; continuous generations while high.
- `step_in` in 1: pulse; run exactly one generation from IDLE.
- `frame_done_in` in 1: pulse at the renderer's end of frame (vsync).
- `rd_addr_out` out ADDR_W: to double buffer `logic_addr_r`.
- `logic_data_r_in` in DATA_W: from double buffer `logic_data_r`.
- `kernel_valid_out` out 1: `kernel_data_out` is valid this cycle.
- `kernel_data_out` out DATA_W: word to kernel.
- `result_valid_in` in 1: kernel result valid; results arrive in issue order.
- `result_data_in` in DATA_W: kernel result word.
- `wr_addr_out` out ADDR_W: to `logic_addr_w`.
- `wr_data_out` out DATA_W: to `logic_data_w`.
- `wr_en_out` out 1: to `logic_wr_en`.
- `swap_out` out 1: to `swap_in`; one-cycle pulse.
- `busy_out` out 1: high in any state except IDLE.
- `gen_count_out` out 16: completed-generation counter (see Configuration).

## Operation
- States: IDLE, SWEEP, DRAIN, WAIT_FRAME, SWAP.
- IDLE → SWEEP when `run_in` or `step_in` is high. `step_in` outside IDLE is ignored.
- SWEEP: `rd_addr_out` starts at 0 and increments by 1 each cycle. After MAX_ADDR-1 has been issued, go to DRAIN. `rd_addr_out` holds its last value outside SWEEP.
- Read tracking: a READ_LAT-deep valid shift register. `kernel_valid_out` is the shift output. `kernel_data_out` = `logic_data_r_in` (combinational passthrough).
- Write path: each `result_valid_in` in SWEEP or DRAIN registers `wr_en_out`=1, `wr_data_out`=`result_data_in`, and `wr_addr_out`=write counter; the write counter then increments. Results in any other state, or beyond MAX_ADDR writes, are dropped.
- DRAIN → WAIT_FRAME in the cycle the MAX_ADDR-th write is registered.
- WAIT_FRAME → SWAP on `frame_done_in`. Only pulses seen in WAIT_FRAME count; earlier pulses are not latched.
- SWAP: `swap_out`=1 for exactly one cycle. Read/write counters clear, then the FSM goes to IDLE.
- With `run_in` still high, the next SWEEP starts on the cycle after IDLE is entered. This gives the double buffer one cycle to toggle.
- Dropping `run_in` mid-generation does not abort: the generation completes and the FSM parks in IDLE.

## Timing
- Reset (asynchronous): state=IDLE, all counters 0, shift register cleared. Outputs `rd_addr_out`=0, `wr_addr_out`=0, `wr_data_out`=0, `wr_en_out`=0, `kernel_valid_out`=0, `swap_out`=0, `busy_out`=0, `gen_count_out`=0.
- Reset mid-generation abandons the sweep. The back buffer is partially written, and no swap is issued.
- Read latency: address issued at cycle t gives `kernel_valid_out` at t+READ_LAT.
- Write latency: `result_valid_in` at cycle t gives `wr_en_out` at t+1.
- Minimum generation length: 2 (IDLE + SWAP) + MAX_ADDR + kernel latency + frame wait.
- The write counter wraps nowhere: it saturates at MAX_ADDR until SWAP clears it.

## Configuration
- `GEN_COUNT_EN` defined: `gen_count_out` increments (mod 2^16) on every `swap_out` cycle.
- `GEN_COUNT_EN` undefined: counter logic omitted and `gen_count_out` is tied to 0.

## Test plan
All scenarios use MAX_ADDR=8, READ_LAT=2, and a kernel modelled as result = data+1 with 3-cycle latency.
- Reset then `step_in` pulse → `rd_addr_out` 0..7 on consecutive cycles; `kernel_valid_out` high for 8 cycles starting 2 cycles after address 0; writes to addresses 0..7 with data+1; no swap until `frame_done_in`.
- `frame_done_in` pulsed during DRAIN, then again in WAIT_FRAME → only the second pulse produces `swap_out`, exactly 1 cycle wide; `busy_out` drops the cycle after.
- `run_in` held high across 3 generations with `frame_done_in` every 40 cycles → 3 `swap_out` pulses, one per frame; `gen_count_out`=3 with `GEN_COUNT_EN`, 0 without.
- `rst_in` asserted asynchronously mid-SWEEP at address 4 → all outputs 0 immediately; no `swap_out`; a later `step_in` restarts at address 0.
- Spurious `result_valid_in` in IDLE plus a 9th result in DRAIN → `wr_en_out` stays 0 for both.
- `step_in` during SWEEP → ignored; after SWAP the FSM parks in IDLE with `busy_out`=0.

Source files
------------

// File: rtl/generation_ctrl.sv
// generation_ctrl: sweeps the read buffer through the cell kernel, writes results to the back buffer
// and issues a frame-aligned buffer swap. Define GEN_COUNT_EN to enable gen_count_out.
module generation_ctrl #(
    parameter int MAX_ADDR     = 4800,
    parameter int LOG_MAX_ADDR = $clog2(MAX_ADDR),
    parameter int WORD_SIZE    = 16,
    parameter int ADDR_W       = LOG_MAX_ADDR,
    parameter int DATA_W       = WORD_SIZE,
    parameter int READ_LAT     = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              run_in,
    input  logic              step_in,
    input  logic              frame_done_in,
    output logic [ADDR_W-1:0] rd_addr_out,
    input  logic [DATA_W-1:0] logic_data_r_in,
    output logic              kernel_valid_out,
    output logic [DATA_W-1:0] kernel_data_out,
    input  logic              result_valid_in,
    input  logic [DATA_W-1:0] result_data_in,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic [DATA_W-1:0] wr_data_out,
    output logic              wr_en_out,
    output logic              swap_out,
    output logic              busy_out,
    output logic [15:0]       gen_count_out
);
    typedef enum logic [2:0] {IDLE, SWEEP, DRAIN, WAIT_FRAME, SWAP} state_t;
    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [ADDR_W:0]     r_wcnt;
    logic [READ_LAT-1:0] r_vld;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                w_sweep;
    logic                w_last_rd;
    logic                w_wr_acc;
    logic                w_wr_full;
    assign w_sweep   = r_state == SWEEP;
    assign w_last_rd = r_rd_addr == ADDR_W'(MAX_ADDR - 1);
    // the write counter is one bit wider so it can hold MAX_ADDR when saturated
    assign w_wr_full = r_wcnt == (ADDR_W + 1)'(MAX_ADDR);
    assign w_wr_acc  = result_valid_in && (w_sweep || r_state == DRAIN) && !w_wr_full;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:       w_next = (run_in || step_in) ? SWEEP : IDLE;
            SWEEP:      w_next = w_last_rd ? DRAIN : SWEEP;
            DRAIN:      w_next = ((w_wr_acc && r_wcnt == (ADDR_W + 1)'(MAX_ADDR - 1)) || w_wr_full) ? WAIT_FRAME : DRAIN;
            WAIT_FRAME: w_next = frame_done_in ? SWAP : WAIT_FRAME;
            default:    w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state   <= IDLE;
            r_rd_addr <= '0;
            r_wcnt    <= '0;
            r_vld     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_state <= w_next;
            r_vld   <= (r_vld << 1) | READ_LAT'(w_sweep);
            if (r_state == SWAP)
                r_rd_addr <= '0;
            else if (w_sweep && !w_last_rd)
                r_rd_addr <= r_rd_addr + 1'b1;
            if (r_state == SWAP)
                r_wcnt <= '0;
            else if (w_wr_acc)
                r_wcnt <= r_wcnt + 1'b1;
            r_wr_en <= w_wr_acc;
            if (w_wr_acc) begin
                r_wr_addr <= r_wcnt[ADDR_W-1:0];
                r_wr_data <= result_data_in;
            end
        end
    end
    assign rd_addr_out      = r_rd_addr;
    assign kernel_valid_out = r_vld[READ_LAT-1];
    assign kernel_data_out  = logic_data_r_in;
    assign wr_addr_out      = r_wr_addr;
    assign wr_data_out      = r_wr_data;
    assign wr_en_out        = r_wr_en;
    assign swap_out         = r_state == SWAP;
    assign busy_out         = r_state != IDLE;
`ifdef GEN_COUNT_EN
    logic [15:0] r_gen_count;
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            r_gen_count <= '0;
        else if (r_state == SWAP)
            r_gen_count <= r_gen_count + 16'd1;
    end
    assign gen_count_out = r_gen_count;
`else
    assign gen_count_out = 16'd0;
`endif
endmodule

// File: tb/tb_generation_ctrl.sv
// tb_generation_ctrl: random stimulus against a double-buffer/kernel environment and a
// generation-level reference model (address sequence, write order, board contents after swap).
module tb_generation_ctrl;
    localparam int N  = 8;
    localparam int AW = 3;
    localparam int DW = 8;
    localparam int RL = 2;
    logic          clk_in;
    logic          rst_in;
    logic          run_in;
    logic          step_in;
    logic          frame_done_in;
    logic [AW-1:0] rd_addr_out;
    logic [DW-1:0] logic_data_r_in;
    logic          kernel_valid_out;
    logic [DW-1:0] kernel_data_out;
    logic          result_valid_in;
    logic [DW-1:0] result_data_in;
    logic [AW-1:0] wr_addr_out;
    logic [DW-1:0] wr_data_out;
    logic          wr_en_out;
    logic          swap_out;
    logic          busy_out;
    logic [15:0]   gen_count_out;

    generation_ctrl #(.MAX_ADDR(N), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .run_in(run_in), .step_in(step_in),
        .frame_done_in(frame_done_in), .rd_addr_out(rd_addr_out), .logic_data_r_in(logic_data_r_in),
        .kernel_valid_out(kernel_valid_out), .kernel_data_out(kernel_data_out),
        .result_valid_in(result_valid_in), .result_data_in(result_data_in),
        .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out), .wr_en_out(wr_en_out),
        .swap_out(swap_out), .busy_out(busy_out), .gen_count_out(gen_count_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int n_chk;
    int n_pass;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // environment: double buffer with 2-cycle read, kernel = data+1 with 3-cycle latency
    logic [DW-1:0] mem [2][N];
    bit            rbuf;
    logic [AW-1:0] p0, p1;
    logic [2:0]    kv;
    logic [DW-1:0] kd [3];
    logic [DW-1:0] snap [N];
    // reference model of the upcoming cycle
    bit            e_busy, e_swap, e_wr, spur_en;
    int            k, wcnt, e_waddr, exp_gc, n_swap, fcnt;
    logic [DW-1:0] e_wdata;

    task automatic model_rst();
        e_busy = 0; e_swap = 0; e_wr = 0; k = 0; wcnt = 0; exp_gc = 0;
        kv = '0; result_valid_in = 1'b0;
    endtask

    task automatic cyc();
        logic          s_wr, s_swap, s_kv;
        logic [AW-1:0] s_rd, s_wa;
        logic [DW-1:0] s_wd, s_kd, t;
        bit            nb, ns;
        @(negedge clk_in);
        s_wr = wr_en_out; s_swap = swap_out; s_kv = kernel_valid_out;
        s_rd = rd_addr_out; s_wa = wr_addr_out; s_wd = wr_data_out; s_kd = kernel_data_out;
        chk("busy", busy_out, e_busy);
        chk("swap", swap_out, e_swap);
        chk("rd_addr", rd_addr_out, e_busy ? (k < N ? k : N - 1) : 0);
        chk("kvalid", kernel_valid_out, e_busy && k >= RL && k < RL + N);
        chk("wr_en", wr_en_out, e_wr);
        if (e_wr) begin
            chk("wr_addr", wr_addr_out, e_waddr);
            chk("wr_data", wr_data_out, e_wdata);
        end
        chk("gen_count", gen_count_out, exp_gc);
        if (e_wr) wcnt++;
        if (s_swap) n_swap++;
        nb = e_busy ? !e_swap : (run_in || step_in);
        ns = e_busy && !e_swap && wcnt == N && frame_done_in;
        e_wr = result_valid_in && e_busy && wcnt < N;
        e_waddr = wcnt;
        e_wdata = result_data_in;
        if (e_swap) begin
            wcnt = 0;
`ifdef GEN_COUNT_EN
            exp_gc = (exp_gc + 1) % 65536;
`endif
        end
        if (nb && !e_busy) begin
            k = 0;
            for (int a = 0; a < N; a++) snap[a] = mem[rbuf][a];
        end else k++;
        e_busy = nb;
        e_swap = ns;
        @(posedge clk_in);
        #1;
        if (s_wr) mem[!rbuf][s_wa] = s_wd;
        if (s_swap) begin
            rbuf = !rbuf;
            for (int a = 0; a < N; a++) begin
                t = snap[a] + 8'd1;
                chk("board", mem[rbuf][a], t);
            end
        end
        p1 = p0;
        p0 = s_rd;
        logic_data_r_in = mem[rbuf][p1];
        kv = {kv[1:0], s_kv};
        kd[2] = kd[1];
        kd[1] = kd[0];
        kd[0] = s_kd + 8'd1;
        result_valid_in = kv[2];
        result_data_in = kd[2];
        if (!kv[2] && spur_en && $urandom_range(0, 3) == 0 && (!e_busy || wcnt + int'(e_wr) == N)) begin
            result_valid_in = 1'b1;
            result_data_in = DW'($urandom);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && e_busy; i++) begin
            frame_done_in = (i % 25 == 24);
            cyc();
        end
        frame_done_in = 1'b0;
        chk("idle", busy_out, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd"}, rd_addr_out, 0);
        chk({tag, "_wa"}, wr_addr_out, 0);
        chk({tag, "_wd"}, wr_data_out, 0);
        chk({tag, "_we"}, wr_en_out, 0);
        chk({tag, "_kv"}, kernel_valid_out, 0);
        chk({tag, "_swap"}, swap_out, 0);
        chk({tag, "_busy"}, busy_out, 0);
        chk({tag, "_gc"}, gen_count_out, 0);
    endtask

    initial begin
        int base;
        n_chk = 0; n_pass = 0; n_swap = 0; fcnt = 0;
        rst_in = 1'b1; run_in = 1'b0; step_in = 1'b0; frame_done_in = 1'b0;
        result_valid_in = 1'b0; result_data_in = '0; logic_data_r_in = '0;
        rbuf = 0; p0 = '0; p1 = '0; spur_en = 0;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < N; a++) mem[b][a] = DW'($urandom);
        for (int i = 0; i < 3; i++) kd[i] = '0;
        model_rst();
        #12;
        check_zero("reset");
        cyc();
        rst_in = 1'b0;
        repeat (2) cyc();
        // single step, extra step during SWEEP, early frame pulse during DRAIN
        step_in = 1'b1; cyc(); step_in = 1'b0;
        repeat (3) cyc();
        step_in = 1'b1; cyc(); step_in = 1'b0;
        for (int i = 0; i < 40 && !(e_busy && k == 10); i++) cyc();
        frame_done_in = 1'b1; cyc(); frame_done_in = 1'b0;
        for (int i = 0; i < 60 && !(e_busy && wcnt == N); i++) cyc();
        repeat (3) cyc();
        chk("no_early_swap", n_swap, 0);
        frame_done_in = 1'b1; cyc(); frame_done_in = 1'b0;
        repeat (2) cyc();
        chk("swaps_step", n_swap, 1);
        chk("parked_step", busy_out, 0);
        // continuous run across three frames
        base = n_swap;
        run_in = 1'b1;
        for (int i = 0; i < 600 && n_swap < base + 3; i++) begin
            frame_done_in = (fcnt % 40 == 39);
            fcnt++;
            cyc();
        end
        run_in = 1'b0; frame_done_in = 1'b0;
        repeat (2) cyc();
        chk("swaps_run", n_swap - base, 3);
        chk("parked_run", busy_out, 0);
`ifdef GEN_COUNT_EN
        chk("gc_run", gen_count_out, 4);
`else
        chk("gc_run", gen_count_out, 0);
`endif
        // asynchronous reset mid-sweep
        base = n_swap;
        step_in = 1'b1; cyc(); step_in = 1'b0;
        for (int i = 0; i < 20 && !(e_busy && k == 4); i++) cyc();
        chk("rd_before_rst", rd_addr_out, 4);
        #2 rst_in = 1'b1;
        #1 check_zero("async_rst");
        model_rst();
        cyc();
        rst_in = 1'b0;
        spur_en = 1;
        repeat (6) cyc();
        chk("swaps_after_rst", n_swap - base, 0);
        step_in = 1'b1; cyc(); step_in = 1'b0;
        wait_idle();
        chk("swaps_restart", n_swap - base, 1);
        // randomized operation with spurious results in IDLE and after the last write
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) run_in = ~run_in;
            step_in = ($urandom_range(0, 19) == 0);
            frame_done_in = ($urandom_range(0, 29) == 0);
            cyc();
        end
        run_in = 1'b0; step_in = 1'b0; frame_done_in = 1'b0;
        cyc();
        wait_idle();
        repeat (3) cyc();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
